// File: rtl/dequantizer_array.sv
// dequantizer_array
//
// Streaming dequantizer: expands packed signed low-precision lanes to
// accumulator-width signed values by sign extension followed by a left shift.
// Two-stage valid/ready pipeline (capture, scale) with full backpressure.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cfg_valid         load cfg_shift (clamped to MAX_SHIFT) on this edge
//   cfg_shift         unsigned left-shift amount
//   cfg_err           sticky flag: an out-of-range cfg_shift was loaded
//   in_valid/ready    input handshake; in_data holds DEQUANTIZER_SIZE packed lanes
//   out_valid/ready   output handshake; results[i] is the scaled lane i
//   beat_count        number of output handshakes, wraps
module dequantizer_array #(
    parameter int unsigned DEQUANTIZER_SIZE       = 4,
    parameter int unsigned ACCUMULATOR_DATA_WIDTH = 16,
    parameter int unsigned COMPUTE_DATA_WIDTH     = 4,
    parameter int unsigned SHIFT_WIDTH            = 4,
    parameter int unsigned MAX_SHIFT              = ACCUMULATOR_DATA_WIDTH - COMPUTE_DATA_WIDTH,
    parameter int unsigned COUNT_WIDTH            = 16
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       cfg_valid,
    input  logic [SHIFT_WIDTH-1:0]                     cfg_shift,
    output logic                                       cfg_err,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [DEQUANTIZER_SIZE*COMPUTE_DATA_WIDTH-1:0] in_data,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [ACCUMULATOR_DATA_WIDTH-1:0]          results [DEQUANTIZER_SIZE-1:0],
    output logic [COUNT_WIDTH-1:0]                     beat_count
);

    localparam int unsigned EXT_W = ACCUMULATOR_DATA_WIDTH - COMPUTE_DATA_WIDTH;
    localparam logic [SHIFT_WIDTH-1:0] MAX_SHIFT_W = SHIFT_WIDTH'(MAX_SHIFT);

    // Configuration state
    logic [SHIFT_WIDTH-1:0] shift_q, shift_d;
    logic                   cfg_err_q, cfg_err_d;

    // Stage A: sign-extended lanes plus the shift tag captured with the beat
    logic                              a_valid_q, a_valid_d;
    logic [ACCUMULATOR_DATA_WIDTH-1:0] a_lane_q [DEQUANTIZER_SIZE-1:0];
    logic [ACCUMULATOR_DATA_WIDTH-1:0] a_lane_d [DEQUANTIZER_SIZE-1:0];
    logic [SHIFT_WIDTH-1:0]            a_shift_q, a_shift_d;

    // Stage B: scaled results presented downstream
    logic                              b_valid_q, b_valid_d;
    logic [ACCUMULATOR_DATA_WIDTH-1:0] res_q [DEQUANTIZER_SIZE-1:0];
    logic [ACCUMULATOR_DATA_WIDTH-1:0] res_d [DEQUANTIZER_SIZE-1:0];
    logic [COUNT_WIDTH-1:0]            beat_count_q, beat_count_d;

    logic b_accept;
    logic a_advance;
    logic in_hs;
    logic out_hs;
    logic cfg_over;

    always_comb begin
        b_accept  = !b_valid_q || out_ready;
        a_advance = a_valid_q && b_accept;
        in_hs     = in_valid && (!a_valid_q || b_accept);
        out_hs    = b_valid_q && out_ready;
        cfg_over  = 32'(cfg_shift) > MAX_SHIFT;
    end

    // Configuration register; the captured beat of the same edge still sees shift_q.
    always_comb begin
        shift_d   = shift_q;
        cfg_err_d = cfg_err_q;
        if (cfg_valid) begin
            shift_d = cfg_over ? MAX_SHIFT_W : cfg_shift;
            if (cfg_over) begin
                cfg_err_d = 1'b1;
            end
        end
    end

    // Stage A next state
    always_comb begin
        a_valid_d = a_valid_q;
        a_shift_d = a_shift_q;
        a_lane_d  = a_lane_q;
        if (in_hs) begin
            a_valid_d = 1'b1;
            a_shift_d = shift_q;
            for (int i = 0; i < int'(DEQUANTIZER_SIZE); i++) begin
                a_lane_d[i] = {{EXT_W{in_data[i*COMPUTE_DATA_WIDTH + COMPUTE_DATA_WIDTH - 1]}},
                               in_data[i*COMPUTE_DATA_WIDTH +: COMPUTE_DATA_WIDTH]};
            end
        end else if (a_advance) begin
            a_valid_d = 1'b0;
        end
    end

    // Stage B next state; the shift never exceeds MAX_SHIFT so no significant bits drop.
    always_comb begin
        b_valid_d    = b_valid_q;
        res_d        = res_q;
        beat_count_d = beat_count_q;
        if (a_advance) begin
            b_valid_d = 1'b1;
            for (int i = 0; i < int'(DEQUANTIZER_SIZE); i++) begin
                res_d[i] = a_lane_q[i] << a_shift_q;
            end
        end else if (out_hs) begin
            b_valid_d = 1'b0;
        end
        if (out_hs) begin
            beat_count_d = beat_count_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q      <= '0;
            cfg_err_q    <= 1'b0;
            a_valid_q    <= 1'b0;
            a_shift_q    <= '0;
            b_valid_q    <= 1'b0;
            beat_count_q <= '0;
            for (int i = 0; i < int'(DEQUANTIZER_SIZE); i++) begin
                a_lane_q[i] <= '0;
                res_q[i]    <= '0;
            end
        end else begin
            shift_q      <= shift_d;
            cfg_err_q    <= cfg_err_d;
            a_valid_q    <= a_valid_d;
            a_shift_q    <= a_shift_d;
            b_valid_q    <= b_valid_d;
            beat_count_q <= beat_count_d;
            a_lane_q     <= a_lane_d;
            res_q        <= res_d;
        end
    end

    // in_ready depends on out_ready combinationally; out_valid is purely registered.
    always_comb begin
        in_ready   = !a_valid_q || b_accept;
        out_valid  = b_valid_q;
        cfg_err    = cfg_err_q;
        beat_count = beat_count_q;
        results    = res_q;
    end

endmodule
